// File: rtl/carrier_nco.sv
// carrier_nco: numerically controlled oscillator producing a signed sine
// carrier on an AXI4-Stream master with full backpressure.
//
// Datapath: phase accumulator -> S1 phase index -> S2 sign/LUT address ->
// S3 quarter-wave ROM read -> output register (negation). The whole pipeline
// advances together and freezes while the output holds an unaccepted sample.
//
// Build option: define CARRIER_NCO_DITHER_EN to add a 15-bit LFSR value into
// the phase bits below the LUT index before truncation (spur spreading).
// Without it the output is bit-exact to the quarter-wave formula.
//
// Stream handshake: a sample transfers on a rising ACLK edge where
// m_axis_tvalid && m_axis_tready; once m_axis_tvalid is high, m_axis_tdata
// and m_axis_tvalid hold until that transfer, and m_axis_tvalid is a pure
// register output that never depends on m_axis_tready combinationally.

module carrier_nco #(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      en,
  input  logic [PHASE_W-1:0]        cfg_phase_inc,
  input  logic [PHASE_W-1:0]        cfg_phase_off,
  input  logic                      cfg_load,
  output logic signed [OUT_W-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int  IDX_W     = LUT_AW + 2;
  localparam int  LOW_W     = PHASE_W - IDX_W;
  localparam int  LUT_DEPTH = 2 ** LUT_AW;
  localparam int  MAG_W     = OUT_W - 1;
  localparam real HALF_PI   = 1.5707963267948966;

  // Quarter-wave entry k: round(A * sin(pi/2 * (k + 0.5) / depth)), with
  // A = 2^(OUT_W-1) - 1. The half-step offset makes address mirroring exact.
  // Evaluated only at elaboration; the sine is a Taylor series in reals.
  function automatic logic [MAG_W-1:0] lut_entry(input int k);
    real x;
    real term;
    real sum;
    real amp;
    x    = HALF_PI * (real'(k) + 0.5) / real'(LUT_DEPTH);
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = real'((2 ** (OUT_W - 1)) - 1);
    return MAG_W'($rtoi(amp * sum + 0.5));
  endfunction

  // Constant quarter-wave table (read through a register in S3).
  logic [MAG_W-1:0] lut_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [MAG_W-1:0] ENTRY = lut_entry(k);
    assign lut_rom[k] = ENTRY;
  end

  // Active tuning words and accumulator.
  logic [PHASE_W-1:0] inc_r;
  logic [PHASE_W-1:0] off_r;
  logic [PHASE_W-1:0] acc;

  // Pipeline stage registers.
  logic               s1_valid;
  logic [IDX_W-1:0]   s1_idx;
  logic               s2_valid;
  logic               s2_sign;
  logic [LUT_AW-1:0]  s2_addr;
  logic               s3_valid;
  logic               s3_sign;
  logic [MAG_W-1:0]   s3_mag;

  // Pipeline control: move everything when the output slot is free or draining.
  logic advance;
  logic inject;
  assign advance = !m_axis_tvalid || m_axis_tready;
  assign inject  = en && advance;

  // Phase of the sample being injected this cycle.
  logic [PHASE_W-1:0] dither;
  logic [PHASE_W-1:0] phase_sum;
  logic [IDX_W-1:0]   phase_idx;
  logic               unused_low;

`ifdef CARRIER_NCO_DITHER_EN
  localparam int DITH_W = (LOW_W < 15) ? LOW_W : 15;

  logic [14:0] lfsr;
  logic        unused_lfsr;

  // Fibonacci LFSR x^15 + x^14 + 1, one step per injected sample.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      lfsr <= 15'h0001;
    end else if (inject) begin
      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end
  end

  assign dither      = PHASE_W'(lfsr[DITH_W-1:0]);
  assign unused_lfsr = ^lfsr;
`else
  assign dither = '0;
`endif

  assign phase_sum  = acc + off_r + dither;
  assign phase_idx  = phase_sum[PHASE_W-1 -: IDX_W];
  assign unused_low = ^phase_sum[LOW_W-1:0];

  // Tuning registers: load on the pulse independent of stall and enable.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      inc_r <= '0;
      off_r <= '0;
    end else if (cfg_load) begin
      inc_r <= cfg_phase_inc;
      off_r <= cfg_phase_off;
    end
  end

  // Accumulator steps by the (pre-load) increment on each injection.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc <= '0;
    end else if (inject) begin
      acc <= acc + inc_r;
    end
  end

  // S1: capture phase index of the injected sample.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else if (advance) begin
      s1_valid <= inject;
      s1_idx   <= phase_idx;
    end
  end

  // S2: split into sign (half-cycle) and mirrored quarter-wave address.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_addr  <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_idx[IDX_W-1];
      s2_addr  <= s1_idx[LUT_AW] ? ~s1_idx[LUT_AW-1:0] : s1_idx[LUT_AW-1:0];
    end
  end

  // S3: synchronous ROM read of the magnitude.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s3_valid <= 1'b0;
      s3_sign  <= 1'b0;
      s3_mag   <= '0;
    end else if (advance) begin
      s3_valid <= s2_valid;
      s3_sign  <= s2_sign;
      s3_mag   <= lut_rom[s2_addr];
    end
  end

  // Magnitude widened with a zero sign bit; entries never reach 2^(OUT_W-1).
  logic signed [OUT_W-1:0] mag_ext;
  assign mag_ext = {1'b0, s3_mag};

  // Output register: apply the sign, hold while the consumer stalls.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (advance) begin
      m_axis_tvalid <= s3_valid;
      m_axis_tdata  <= s3_sign ? -mag_ext : mag_ext;
    end
  end

endmodule

// File: tb/tb_carrier_nco.sv
// tb_carrier_nco: directed checks of the carrier NCO stream (default build).

module tb_carrier_nco;

  localparam int PHASE_W = 32;
  localparam int LUT_AW  = 10;
  localparam int OUT_W   = 16;

  // Clock / reset and DUT signals.
  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               en;
  logic [PHASE_W-1:0] cfg_phase_inc;
  logic [PHASE_W-1:0] cfg_phase_off;
  logic               cfg_load;
  logic [OUT_W-1:0]   m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected samples in stream order.
  logic [OUT_W-1:0] exp_q[$];

  // Quarter-point sample values: phases 0, 1/4, 1/2, 3/4 of a cycle.
  int quad_pat[4] = '{25, 32767, -25, -32767};

  always #5 ACLK = ~ACLK;

  carrier_nco #(
    .PHASE_W(PHASE_W),
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .en            (en),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_phase_off (cfg_phase_off),
    .cfg_load      (cfg_load),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  // One clock: outputs are sampled and inputs changed 1 time unit after the edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [OUT_W-1:0] got,
                            input logic [OUT_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic push(input int v);
    exp_q.push_back(OUT_W'(v));
  endtask

  // Driver: pulse cfg_load for one cycle with the given tuning words.
  task automatic load_cfg(input logic [PHASE_W-1:0] inc, input logic [PHASE_W-1:0] off);
    cfg_phase_inc = inc;
    cfg_phase_off = off;
    cfg_load      = 1'b1;
    step();
    cfg_load      = 1'b0;
  endtask

  // Driver: one-cycle synchronous reset with injection disabled.
  task automatic reset_pulse();
    ARESET = 1'b1;
    en     = 1'b0;
    step();
    ARESET = 1'b0;
  endtask

  // Check n consecutive accepted samples against the scoreboard (tready high).
  task automatic expect_samples(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      logic [OUT_W-1:0] e;
      check_bit({tag, "_tvalid"}, m_axis_tvalid, 1'b1);
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL %s_queue: observed empty expected queue entry", tag);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_word({tag, "_tdata"}, m_axis_tdata, e);
      end
      step();
    end
  endtask

  initial begin
    ARESET        = 1'b1;
    en            = 1'b0;
    cfg_load      = 1'b0;
    cfg_phase_inc = '0;
    cfg_phase_off = '0;
    m_axis_tready = 1'b1;
    step();
    step();

    // Reset state.
    check_bit("rst_tvalid", m_axis_tvalid, 1'b0);
    check_word("rst_tdata", m_axis_tdata, '0);
    ARESET = 1'b0;

    // Quarter-cycle stream: latency, stall, resume, drain.
    load_cfg(32'h4000_0000, 32'h0000_0000);
    for (int i = 0; i < 18; i++) push(quad_pat[i % 4]);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("latency_tvalid", m_axis_tvalid, 1'b0);
    end
    step();
    expect_samples("quad", 6);

    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_bit("stall_tvalid", m_axis_tvalid, 1'b1);
      check_word("stall_tdata", m_axis_tdata, exp_q[0]);
    end
    m_axis_tready = 1'b1;
    expect_samples("resume", 8);
    en = 1'b0;
    expect_samples("drain", 4);
    check_bit("drain_idle", m_axis_tvalid, 1'b0);

    // Zero increment with half-cycle offset: constant negative minimum entry.
    reset_pulse();
    load_cfg(32'h0000_0000, 32'h8000_0000);
    for (int i = 0; i < 6; i++) push(-25);
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    expect_samples("const", 6);
    en = 1'b0;

    // Load coincident with the 4th injection: that sample keeps the old step.
    reset_pulse();
    load_cfg(32'h4000_0000, 32'h0000_0000);
    push(25); push(32767); push(-25); push(-32767);
    push(25); push(-25);   push(25);  push(-25);
    en = 1'b1;
    step();
    step();
    step();
    cfg_phase_inc = 32'h8000_0000;
    cfg_load      = 1'b1;
    step();
    cfg_load      = 1'b0;
    expect_samples("coinc", 8);
    en = 1'b0;

    // Phase wrap: 2^32-1 is quadrant 3 mirrored to address 0, then phase 0.
    reset_pulse();
    load_cfg(32'h0000_0001, 32'hFFFF_FFFF);
    push(-25); push(25); push(25); push(25);
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    expect_samples("wrap", 4);
    en = 1'b0;

    // Reset with three samples in flight: nothing stale, restart with inc_r=0.
    reset_pulse();
    load_cfg(32'h4000_0000, 32'h0000_0000);
    en = 1'b1;
    step();
    step();
    step();
    ARESET = 1'b1;
    step();
    check_bit("midrst_tvalid", m_axis_tvalid, 1'b0);
    check_word("midrst_tdata", m_axis_tdata, '0);
    ARESET = 1'b0;
    for (int i = 0; i < 3; i++) push(25);
    for (int i = 0; i < 3; i++) begin
      step();
      check_bit("no_stale_tvalid", m_axis_tvalid, 1'b0);
    end
    step();
    expect_samples("restart", 3);
    en = 1'b0;

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover_queue: observed %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
